// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 mux output channel between four
// valid/ready requesters. Drives the registered mux select and a one-hot grant,
// and limits each grant to HOLD_MAX beats so that no requester starves the others.
//
// state | meaning
// IDLE  | no owner; scans req starting at ptr and registers the winner into sel
// GRANT | lane sel owns the channel; counts beats until the hold limit or req drops
module mux4_rr_arbiter #(
    parameter int DW       = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] in_data,
    output logic [3:0]      in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    input  logic            out_ready,
    output logic [1:0]      sel,
    output logic [3:0]      grant,
    output logic            busy
);

    localparam int BW = $clog2(HOLD_MAX + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_nx;
    logic [1:0]      sel_q, sel_nx;
    logic [1:0]      ptr_q, ptr_nx;
    logic [BW-1:0]   beat_q, beat_nx;
    logic [1:0]      winner;
    logic [1:0]      scan_idx;
    logic            found;
    logic            xfer;

    // Priority scan of req beginning at ptr, wrapping 3 -> 0.
    always_comb begin
        winner   = ptr_q;
        scan_idx = ptr_q;
        found    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    // Channel outputs depend only on registered state/sel and the request inputs,
    // so out_valid never depends on out_ready.
    always_comb begin
        busy      = (state_q == GRANT);
        sel       = sel_q;
        grant     = busy ? (4'b0001 << sel_q) : 4'b0000;
        out_valid = busy & req[sel_q];
        in_ready  = busy ? ((4'b0001 << sel_q) & {4{out_ready}}) : 4'b0000;
        out_data  = in_data[sel_q*DW +: DW];
        xfer      = out_valid & out_ready;
    end

    // Next-state logic: arbitration in IDLE, beat metering and release in GRANT.
    always_comb begin
        state_nx = state_q;
        sel_nx   = sel_q;
        ptr_nx   = ptr_q;
        beat_nx  = beat_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_nx   = winner;
                    beat_nx  = '0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                // A dropped request releases the channel; no beat can occur then
                // because out_valid is low.
                if ((xfer && beat_q == LAST_BEAT) || !req[sel_q]) begin
                    state_nx = IDLE;
                    ptr_nx   = sel_q + 2'd1;
                    beat_nx  = '0;
                end else if (xfer && beat_q != LAST_BEAT) begin
                    beat_nx = beat_q + BW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register; reset aborts any grant in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            beat_q  <= '0;
        end else begin
            state_q <= state_nx;
            sel_q   <= sel_nx;
            ptr_q   <= ptr_nx;
            beat_q  <= beat_nx;
        end
    end

endmodule
